// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch sequencer. Owns the PC, issues requests to the
// instruction ROM over a valid/ack handshake (any latency), and presents
// fetched instructions to IF/ID with downstream stall and redirect handling.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   jump_en_i, jump_addr_i    redirect request and target (bits [1:0] ignored)
//   hold_i                    IF/ID cannot accept a new instruction
//   rom_req_o, rom_addr_o     ROM request valid / address
//   rom_ack_i, rom_inst_i     ROM response strobe / read data
//   inst_valid_o              inst_o / inst_addr_o carry a live instruction
//   inst_addr_o, inst_o       presented instruction and its address
//   pc_o                      current fetch PC
//
// state | meaning
// IDLE  | post-reset cycle, no request
// ISSUE | request at pc outstanding until ack
// STALL | ack arrived under hold; instruction parked in skid buffer
// KILL  | redirect hit an unacked request; wait for its ack, drop data
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_inst_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, STALL, KILL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic [31:0] inst_q, inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_addr_q, skid_addr_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] saved_q, saved_d;

    logic [31:0] jump_tgt;
    logic        unused_jump_lsb;

    assign jump_tgt        = {jump_addr_i[31:2], 2'b00};
    assign unused_jump_lsb = ^jump_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
            iaddr_q      <= 32'h0;
            inst_q       <= NOP_INST;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= 32'h0;
            skid_inst_q  <= 32'h0;
            saved_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            iaddr_q      <= iaddr_d;
            inst_q       <= inst_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_inst_q  <= skid_inst_d;
            saved_q      <= saved_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        iaddr_d      = iaddr_q;
        inst_d       = inst_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_inst_d  = skid_inst_q;
        saved_d      = saved_q;

        if (jump_en_i) begin
            // Redirect beats hold and capture: whatever was presented or parked is stale.
            valid_d      = 1'b0;
            inst_d       = NOP_INST;
            skid_valid_d = 1'b0;
            if ((state_q == ISSUE || state_q == KILL) && !rom_ack_i) begin
                // Request still in flight; it must complete before we move the address.
                saved_d = jump_tgt;
                state_d = KILL;
            end else begin
                pc_d    = jump_tgt;
                state_d = ISSUE;
            end
        end else begin
            case (state_q)
                IDLE: state_d = ISSUE;
                ISSUE: begin
                    if (rom_ack_i) begin
                        pc_d = pc_q + 32'd4;
                        if (hold_i) begin
                            skid_valid_d = 1'b1;
                            skid_addr_d  = pc_q;
                            skid_inst_d  = rom_inst_i;
                            state_d      = STALL;
                        end else begin
                            valid_d = 1'b1;
                            iaddr_d = pc_q;
                            inst_d  = rom_inst_i;
                        end
                    end else if (!hold_i) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                STALL: begin
                    if (!hold_i) begin
                        valid_d      = skid_valid_q;
                        iaddr_d      = skid_addr_q;
                        inst_d       = skid_inst_q;
                        skid_valid_d = 1'b0;
                        state_d      = ISSUE;
                    end
                end
                KILL: begin
                    valid_d = 1'b0;
                    if (rom_ack_i) begin
                        pc_d    = saved_q;
                        state_d = ISSUE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rom_req_o    = (state_q == ISSUE) || (state_q == KILL);
    assign rom_addr_o   = pc_q;
    assign inst_valid_o = valid_q;
    assign inst_addr_o  = iaddr_q;
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the RISC-V core front end. It owns the program counter and issues requests to the instruction ROM over a valid/ack handshake, tolerating variable ROM latency. It presents fetched instructions to the IF/ID stage and applies downstream stall (hold) and branch/jump redirect (flush). It replaces the free-running PC-plus-register fetch path with a controlled one.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- NOP_INST, 32'h0000_0013, instruction driven on inst_o when invalid (addi x0,x0,0)

- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- jump_en_i  in  1  redirect request from execute
- jump_addr_i  in  32  redirect target; bits [1:0] ignored (treated as 0)
- hold_i  in  1  downstream stall; IF/ID cannot accept a new instruction
- rom_req_o  out  1  ROM request valid
- rom_addr_o  out  32  ROM request address
- rom_ack_i  in  1  ROM response; rom_inst_i valid in the same cycle
- rom_inst_i  in  32  ROM read data
- inst_valid_o  out  1  inst_o/inst_addr_o carry a live instruction
- inst_addr_o  out  32  address of inst_o
- inst_o  out  32  fetched instruction
- pc_o  out  32  current fetch PC (address of the outstanding or next request)

## Operation
- State machine: IDLE, ISSUE, STALL, KILL.
- Reset (any state, including a request in flight) forces the following; the ROM must tolerate a dropped request:
  - state=IDLE, pc=RESET_PC, rom_req_o=0, rom_addr_o=RESET_PC
  - inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, skid buffer empty, saved target=0
- IDLE: rom_req_o=0; go to ISSUE next cycle.
- ISSUE: rom_req_o=1, rom_addr_o=pc. Address is held stable until rom_ack_i; a request is never withdrawn before ack.
  - ack, !hold_i, !jump: output regs <= {1, pc, rom_inst_i}; pc <= pc+4; stay ISSUE.
  - ack, hold_i, !jump: output regs unchanged; {pc, rom_inst_i} -> skid buffer; pc <= pc+4; go STALL.
  - no ack, !jump: stay ISSUE. If !hold_i, inst_valid_o <= 0 and inst_o <= NOP_INST (bubble); otherwise outputs hold.
- STALL: rom_req_o=0; outputs hold while hold_i=1. When hold_i=0: output regs <= skid entry (valid=1), skid cleared, go ISSUE.
- KILL: rom_req_o=1 with the original address until ack; data on ack is discarded. Then pc <= saved target and go ISSUE. inst_valid_o=0 throughout.
- Jump (jump_en_i=1) has priority over hold_i and over capture. In that cycle: inst_valid_o <= 0, inst_o <= NOP_INST, skid cleared.
  - ISSUE with ack, or IDLE/STALL: pc <= {jump_addr_i[31:2],2'b00}; go ISSUE (IDLE goes ISSUE anyway).
  - ISSUE without ack: saved target <= jump addr; go KILL.
  - KILL: saved target overwritten by the newest jump; if ack arrives the same cycle, pc <= new target, go ISSUE.
- pc arithmetic is modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0.
- pc_o = pc register; in KILL it shows the killed address.

## Timing
- First rom_req_o=1 is the second cycle after rst deasserts (IDLE lasts one cycle).
- rom_ack_i in cycle N -> inst_valid_o/inst_o updated at edge ending N (visible N+1). Fetch-to-output latency is 1 cycle after ack.
- Zero-wait ROM (ack every cycle) gives 1 instruction/cycle sustained, with no bubbles and no lost or duplicated instruction across hold.
- Jump in cycle N gives inst_valid_o=0 in N+1; the first target instruction appears 1 cycle after its ack.
- A hold asserted while ISSUE has no ack still leaves the request outstanding; on its ack the data goes to the skid buffer.

## Test plan
- Reset release, ack tied 1, rom_inst_i=rom_addr_o: rom_req_o rises cycle 2. From cycle 3, inst_addr_o/inst_o = 0,4,8,... one per cycle with valid=1.
- ROM acks 3 cycles after each request: rom_addr_o stays 0x4 for 3 cycles and pc_o=0x4. inst_valid_o pulses 1 cycle per instruction with NOP bubbles between.
- hold_i=1 for 4 cycles coincident with ack of 0x8: rom_req_o=0 during STALL and outputs hold at 0x4. After release, 0x8 is presented, then 0xC; no gap, no duplicate.
- jump_en_i to 0x100 while request 0x10 is outstanding (ack 2 cycles later): state KILL, 0x10 data discarded, next rom_addr_o=0x100, inst_valid_o=0 until 0x100 delivered.
- jump_en_i and hold_i both 1 with a valid instruction held: inst_valid_o=0 and inst_o=0x00000013 next cycle; fetch resumes at the target.
- RESET_PC=32'hFFFF_FFF8, ack every cycle: inst_addr_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Mid-stream rst pulse returns all outputs to reset values next cycle.
